// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT butterfly scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package fft_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bf_state_e;

  localparam int FFT_LOG2_256  = 8;
  localparam int FFT_LOG2_1024 = 10;
  localparam int TW_N          = 1024;
  localparam int N4            = 256;
  localparam int STAGE_W       = 4;

  // Index of the final stage for the selected transform size
  function automatic int last_stage(input logic big);
    return big ? (FFT_LOG2_1024 - 1) : (FFT_LOG2_256 - 1);
  endfunction

  // Butterflies per stage (N/2) for the selected transform size
  function automatic int half_pts(input logic big);
    return big ? (TW_N / 2) : (N4 / 2);
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address and twiddle exponent generator for one (counter, stage) pair.
// Latency: purely combinational, registered by the caller.
// Backpressure: none; outputs follow inputs.
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-2:0]  c_i,
  input  logic [STAGE_W-1:0] stage_i,
  output logic [ADDR_W-1:0]  addr_a_o,
  output logic [ADDR_W-1:0]  addr_b_o,
  output logic [ADDR_W-1:0]  tw_idx_o
);

  logic [ADDR_W-1:0]  cw;
  logic [ADDR_W-1:0]  h;
  logic [ADDR_W-1:0]  mask;
  logic [STAGE_W-1:0] tw_sh;

  // Insert a zero at bit 'stage' of c for leg A; leg B sets that bit.
  // The twiddle exponent is the low 'stage' bits of c scaled to the 1024-point circle.
  always_comb begin
    cw       = {1'b0, c_i};
    h        = ADDR_W'(1) << stage_i;
    mask     = h - ADDR_W'(1);
    addr_a_o = ((cw & ~mask) << 1) | (cw & mask);
    addr_b_o = addr_a_o | h;
    tw_sh    = STAGE_W'(ADDR_W - 1) - stage_i;
    tw_idx_o = (cw & mask) << tw_sh;
  end

endmodule

// File: rtl/fft_bf_scheduler.sv
// Sequences all butterflies of an in-place radix-2 DIT FFT (256 or 1024 points).
// Latency: first address set one cycle after start; all outputs registered.
// Backpressure: address set holds until bf_ready; DRAIN_CYCLES bubble after each stage.
module fft_bf_scheduler
  import fft_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_1024,
  input  logic               bf_ready,
  output logic               bf_valid,
  output logic [ADDR_W-1:0]  addr_a,
  output logic [ADDR_W-1:0]  addr_b,
  output logic [ADDR_W-1:0]  tw_idx,
  output logic               size_1024,
  output logic [STAGE_W-1:0] stage,
  output logic               last_bf,
  output logic               busy,
  output logic               done
);

  localparam int CW = ADDR_W - 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  bf_state_e          state_q, state_d;
  logic [CW-1:0]      c_q, c_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               size_q, size_d;

  logic               bf_valid_q, busy_q, done_q, last_bf_q;
  logic [ADDR_W-1:0]  addr_a_q, addr_b_q, tw_idx_q;

  logic [ADDR_W-1:0]  gen_a, gen_b, gen_tw;
  logic [CW-1:0]      c_last_q, c_last_d;
  logic [STAGE_W-1:0] stage_last_q;
  logic               accept;
  logic               run_d;

  // Addresses are generated from next-state counters so the registered set lines up with state
  fft_bf_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .c_i      (c_d),
    .stage_i  (stage_d),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  // Per-size limits and handshake qualification
  always_comb begin
    c_last_q     = CW'(half_pts(size_q) - 1);
    c_last_d     = CW'(half_pts(size_d) - 1);
    stage_last_q = STAGE_W'(last_stage(size_q));
    accept       = bf_valid_q & bf_ready;
    run_d        = (state_d == ST_RUN);
  end

  // Next-state logic for FSM, butterfly counter, stage counter, drain counter and size latch
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    stage_d = stage_q;
    drain_d = drain_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          c_d     = '0;
          stage_d = '0;
          drain_d = '0;
          size_d  = is_1024;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (c_q == c_last_q) begin
            c_d = '0;
            if (DRAIN_CYCLES == 0) begin
              // No bubble: roll directly into the next stage
              if (stage_q == stage_last_q) begin
                state_d = ST_DONE;
              end else begin
                stage_d = stage_q + 1'b1;
              end
            end else begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          if (stage_q == stage_last_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + 1'b1;
            c_d     = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
        c_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transform in flight without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      c_q        <= '0;
      stage_q    <= '0;
      drain_q    <= '0;
      size_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_bf_q  <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      stage_q    <= stage_d;
      drain_q    <= drain_d;
      size_q     <= size_d;
      bf_valid_q <= run_d;
      busy_q     <= run_d || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
      last_bf_q  <= run_d && (c_d == c_last_d);
      addr_a_q   <= run_d ? gen_a  : '0;
      addr_b_q   <= run_d ? gen_b  : '0;
      tw_idx_q   <= run_d ? gen_tw : '0;
    end
  end

  assign bf_valid  = bf_valid_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign size_1024 = size_q;
  assign stage     = stage_q;
  assign last_bf   = last_bf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Self-checking bench for fft_bf_scheduler.
// Latency: n/a.
// Backpressure: bf_ready driven directly and randomly in one sequence.
module tb_fft_bf_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, is_1024, bf_ready;
  logic       bf_valid, size_1024, last_bf, busy, done;
  logic [9:0] addr_a, addr_b, tw_idx;
  logic [3:0] stage;

  fft_bf_scheduler #(.ADDR_W(10), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_1024(is_1024), .bf_ready(bf_ready),
    .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
    .size_1024(size_1024), .stage(stage), .last_bf(last_bf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected snapshot at a given cycle after the start edge (start edge -> cycle 1)
  typedef struct {
    logic       sz;
    int         cyc;
    logic       vld;
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] tw;
    logic [3:0] st;
    logic       last;
  } vec_t;

  localparam int NV  = 21;
  localparam int LIM = 6000;
  vec_t tbl[NV];

  logic [9:0] r_a[LIM];
  logic [9:0] r_b[LIM];
  logic [9:0] r_tw[LIM];
  logic [3:0] r_st[LIM];
  logic       r_v[LIM];
  logic       r_l[LIM];
  logic       r_sz[LIM];
  int         done_cyc;
  logic       done_busy;

  // Run one transform with bf_ready high, recording every cycle until done
  task automatic run_full(input logic sz);
    int  cyc;
    bit  fin;
    @(negedge clk);
    is_1024  = sz;
    start    = 1'b1;
    bf_ready = 1'b1;
    @(posedge clk); #1;
    cyc      = 1;
    fin      = 1'b0;
    done_cyc = -1;
    while (cyc < LIM && !fin) begin
      r_a[cyc]  = addr_a;
      r_b[cyc]  = addr_b;
      r_tw[cyc] = tw_idx;
      r_st[cyc] = stage;
      r_v[cyc]  = bf_valid;
      r_l[cyc]  = last_bf;
      r_sz[cyc] = size_1024;
      if (done) begin
        done_cyc  = cyc;
        done_busy = busy;
        fin       = 1'b1;
      end else begin
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk($sformatf("done_cycle_sz%0d", sz), done_cyc, sz ? 5161 : 1057);
    chk("busy_in_done", done_busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic apply_table(input logic sz);
    int k;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].sz == sz) begin
        k = tbl[i].cyc;
        chk($sformatf("vec%0d_vld", i), r_v[k], tbl[i].vld);
        chk($sformatf("vec%0d_stage", i), r_st[k], tbl[i].st);
        chk($sformatf("vec%0d_last", i), r_l[k], tbl[i].last);
        if (tbl[i].vld) begin
          chk($sformatf("vec%0d_addr_a", i), r_a[k], tbl[i].a);
          chk($sformatf("vec%0d_addr_b", i), r_b[k], tbl[i].b);
          chk($sformatf("vec%0d_tw", i), r_tw[k], tbl[i].tw);
          chk($sformatf("vec%0d_size", i), r_sz[k], sz);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int   acc, dup, hold_err, drain_err, geo_err, gap, covered, dones, first_done, post_act;
    int   cyc;
    bit   fin, prev_hold;
    logic [9:0] pa, pb, ptw;
    logic [3:0] pst;
    bit   seen[2048];

    //            sz    cyc   vld  a     b      tw    st  last
    tbl[0]  = '{1'b0,    1, 1'b1, 10'd0,   10'd1,    10'd0,   4'd0, 1'b0};
    tbl[1]  = '{1'b0,    4, 1'b1, 10'd6,   10'd7,    10'd0,   4'd0, 1'b0};
    tbl[2]  = '{1'b0,  128, 1'b1, 10'd254, 10'd255,  10'd0,   4'd0, 1'b1};
    tbl[3]  = '{1'b0,  129, 1'b0, 10'd0,   10'd0,    10'd0,   4'd0, 1'b0};
    tbl[4]  = '{1'b0,  132, 1'b0, 10'd0,   10'd0,    10'd0,   4'd0, 1'b0};
    tbl[5]  = '{1'b0,  133, 1'b1, 10'd0,   10'd2,    10'd0,   4'd1, 1'b0};
    tbl[6]  = '{1'b0,  134, 1'b1, 10'd1,   10'd3,    10'd256, 4'd1, 1'b0};
    tbl[7]  = '{1'b0,  270, 1'b1, 10'd9,   10'd13,   10'd128, 4'd2, 1'b0};
    tbl[8]  = '{1'b0,  407, 1'b1, 10'd18,  10'd26,   10'd128, 4'd3, 1'b0};
    tbl[9]  = '{1'b0,  925, 1'b1, 10'd0,   10'd128,  10'd0,   4'd7, 1'b0};
    tbl[10] = '{1'b0,  926, 1'b1, 10'd1,   10'd129,  10'd4,   4'd7, 1'b0};
    tbl[11] = '{1'b0, 1052, 1'b1, 10'd127, 10'd255,  10'd508, 4'd7, 1'b1};
    tbl[12] = '{1'b0, 1053, 1'b0, 10'd0,   10'd0,    10'd0,   4'd7, 1'b0};
    tbl[13] = '{1'b1,    1, 1'b1, 10'd0,   10'd1,    10'd0,   4'd0, 1'b0};
    tbl[14] = '{1'b1, 2681, 1'b1, 10'd196, 10'd228,  10'd64,  4'd5, 1'b0};
    tbl[15] = '{1'b1, 4429, 1'b1, 10'd556, 10'd812,  10'd88,  4'd8, 1'b0};
    tbl[16] = '{1'b1, 4645, 1'b1, 10'd0,   10'd512,  10'd0,   4'd9, 1'b0};
    tbl[17] = '{1'b1, 4646, 1'b1, 10'd1,   10'd513,  10'd1,   4'd9, 1'b0};
    tbl[18] = '{1'b1, 5156, 1'b1, 10'd511, 10'd1023, 10'd511, 4'd9, 1'b1};
    tbl[19] = '{1'b1,  516, 1'b0, 10'd0,   10'd0,    10'd0,   4'd0, 1'b0};
    tbl[20] = '{1'b1,  517, 1'b1, 10'd0,   10'd2,    10'd0,   4'd1, 1'b0};

    // Reset with start held high: everything must stay at zero
    rst = 1'b1; start = 1'b1; is_1024 = 1'b1; bf_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bf_valid", bf_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_tw", tw_idx, 0);
    chk("rst_stage", stage, 0);
    chk("rst_size", size_1024, 0);
    chk("rst_last", last_bf, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);

    // Full 256-point and 1024-point transforms against the table
    run_full(1'b0);
    apply_table(1'b0);
    run_full(1'b1);
    apply_table(1'b1);

    // Random backpressure on a 256-point transform
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
    acc = 0; dup = 0; hold_err = 0; drain_err = 0; geo_err = 0; gap = 0;
    prev_hold = 1'b0; pa = '0; pb = '0; ptw = '0; pst = '0;
    @(negedge clk);
    is_1024 = 1'b0; start = 1'b1; bf_ready = 1'b0;
    @(posedge clk); #1;
    cyc = 1; fin = 1'b0;
    while (cyc < 4000 && !fin) begin
      if (prev_hold && (!bf_valid || addr_a != pa || addr_b != pb || tw_idx != ptw || stage != pst))
        hold_err++;
      if (gap > 0) begin
        if (bf_valid) drain_err++;
        gap--;
      end
      if (done) begin
        fin = 1'b1;
      end else begin
        @(negedge clk);
        start    = 1'b0;
        bf_ready = ($urandom_range(0, 2) != 0);
        if (bf_valid && bf_ready) begin
          acc++;
          if (addr_b != (addr_a | (10'd1 << stage)) || addr_a[stage]) geo_err++;
          if (seen[stage*256 + addr_a]) dup++;
          seen[stage*256 + addr_a] = 1'b1;
          if (seen[stage*256 + addr_b]) dup++;
          seen[stage*256 + addr_b] = 1'b1;
          if (last_bf) gap = 4;
        end
        prev_hold = bf_valid && !bf_ready;
        pa = addr_a; pb = addr_b; ptw = tw_idx; pst = stage;
        @(posedge clk); #1;
        cyc++;
      end
    end
    covered = 0;
    for (int i = 0; i < 2048; i++) covered += int'(seen[i]);
    chk("rand_done_reached", int'(fin), 1);
    chk("rand_accepts", acc, 1024);
    chk("rand_dup_pairs", dup, 0);
    chk("rand_covered", covered, 2048);
    chk("rand_hold_err", hold_err, 0);
    chk("rand_drain_valid", drain_err, 0);
    chk("rand_geometry", geo_err, 0);
    @(negedge clk);
    bf_ready = 1'b1;
    repeat (2) @(posedge clk);

    // start pulsed mid-RUN and during the done cycle must be ignored
    dones = 0; first_done = -1; post_act = 0;
    @(negedge clk);
    is_1024 = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 1200; c++) begin
      if (done) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      if (first_done >= 0 && c > first_done && (busy || bf_valid || done)) post_act++;
      @(negedge clk);
      start = (c == 50) || done;
      @(posedge clk); #1;
    end
    chk("poke_done_count", dones, 1);
    chk("poke_done_cycle", first_done, 1057);
    chk("poke_post_activity", post_act, 0);

    // Reset in stage 3 of a 1024-point transform
    @(negedge clk);
    is_1024 = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 1559; c++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
    end
    chk("mid_stage_before_rst", stage, 3);
    chk("mid_valid_before_rst", bf_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bf_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_stage", stage, 0);
    chk("mid_rst_size", size_1024, 0);
    @(negedge clk);
    rst = 1'b0;
    post_act = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (busy || done || bf_valid) post_act++;
    end
    chk("after_rst_idle", post_act, 0);
    run_full(1'b0);
    apply_table(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
